para_to_ser: RTL
================

Name: para_to_ser

Overview:
Parallel-to-serial transmitter, the sending end of the serial byte link whose receiving end is Ser_to_Para. It accepts a WIDTH-bit word over a valid/ready load handshake and shifts it out one bit per clk. Bits go LSB-first by default, matching Ser_to_Para framing. A per-bit out_valid qualifies the stream and can drive the receiver's en directly. Back-to-back words stream with no idle gap.

Parameters:
WIDTH, 8, word width in bits; legal range 2..128 (128 covers full AES state transfer).
MSB_FIRST, 0, 0 = bit 0 sent first; 1 = bit WIDTH-1 sent first.

Ports:
clk  input  1  rising-edge clock.
rst  input  1  asynchronous active-low reset; all state clears while rst==0.
en  input  1  shift enable; when low, the block freezes.
data_in  input  WIDTH  word to transmit; sampled only on an accepted load.
load  input  1  load request (valid).
ready  output  1  block can accept a word this cycle.
out  output  1  serial data bit.
out_valid  output  1  out carries a valid bit this cycle.
last  output  1  high while the final bit of a word is on out.

Behaviour:
- Reset (rst==0, async): state=IDLE; out=0, out_valid=0, last=0; bit counter=0; shift register=0. A word in flight is discarded; after reset release there is no partial resend.
- Registered state: FSM {IDLE, SHIFT}, cnt[$clog2(WIDTH)-1:0], shreg[WIDTH-1:0], out_q, valid_q, last_q.
- ready = en & ((state==IDLE) | (state==SHIFT & cnt==WIDTH-1)). Combinational; there is no path from load to ready.
- Accept = load & ready at a rising edge. That edge does the following:
  - shreg <= data_in.
  - out_q <= first bit (data_in[0], or data_in[WIDTH-1] if MSB_FIRST).
  - cnt <= 0, valid_q <= 1, state <= SHIFT.
  - last_q <= 0, since WIDTH>=2.
- Latency: the first bit appears on out in the cycle after the accept edge. Bit k is on out during cycle k+1 after accept, k = 0..WIDTH-1.
- In SHIFT with en=1 and cnt<WIDTH-1: cnt++, out_q <= next bit, last_q <= (cnt+1==WIDTH-1).
- In SHIFT with en=1 and cnt==WIDTH-1, the last bit is on out:
  - If accept: start the new word as above, with no gap cycle.
  - Else: state <= IDLE, valid_q <= 0, out_q <= 0, last_q <= 0.
- en==0: every register holds, and ready=0.
  - out_valid = valid_q & en, so the receiver gated by out_valid does not sample a held bit twice.
  - last = last_q & en.
  - out holds its value.
- load while ready==0 is ignored. data_in is not captured, and nothing is queued.
- data_in may change freely except at the accept edge.
- Exactly WIDTH out_valid cycles per accepted word. last is asserted on exactly one of them, the final one.

Decomposition:
- Shared package para_ser_pkg holds:
  - state encoding localparams ST_IDLE=1'b0, ST_SHIFT=1'b1.
  - default word width BYTE_W=8.
  - bit-order constants LSB_FIRST=0, MSB_FIRST=1.
- No sub-module: the counter and shifter are small and inline. The team-wide serial-link loopback bench instantiates para_to_ser with Ser_to_Para.

Test Plan:
1. Reset 10 ns, en=1, load 8'h15 for one cycle -> out over 8 cycles = 1,0,1,0,1,0,0,0; out_valid high 8 cycles; last only on the 8th; ready low for cycles 1-7 and high on the 8th.
2. Back-to-back: load 8'hFF, then hold load high with 8'hC8 presented -> 1x8 then 0,0,0,1,0,0,1,1 with no out_valid gap; last pulses twice, 8 cycles apart.
3. load pulsed with 8'hAA during bit 3 of 8'h15 -> ignored; stream stays 8'h15; out_valid drops after the 8th bit.
4. en low for 3 cycles after bit 2 of 8'h15 -> out holds bit 2, out_valid=0, ready=0; after resume, bits 3-7 follow; total valid bits = 8.
5. rst asserted mid-word (after bit 4) -> out, out_valid, last go 0 immediately (async); after release, ready=1 and no further bits are sent until the next load.
6. MSB_FIRST=1, WIDTH=8, load 8'h15 -> out = 0,0,0,1,0,1,0,1; WIDTH=16 with 16'hA5C3 LSB-first -> 16 bits, last on the 16th.

Source files
------------

// File: rtl/para_ser_pkg.sv
// Shared constants for the parallel/serial byte link: state encoding,
// default word width and bit-order selectors.
package para_ser_pkg;

    localparam logic ST_IDLE  = 1'b0;
    localparam logic ST_SHIFT = 1'b1;

    localparam int BYTE_W    = 8;
    localparam int LSB_FIRST = 0;
    localparam int MSB_FIRST = 1;

    typedef enum logic {
        S_IDLE  = ST_IDLE,
        S_SHIFT = ST_SHIFT
    } p2s_state_e;

endpackage

// File: rtl/para_to_ser.sv
// Parallel-to-serial transmitter: takes a WIDTH-bit word on a load/ready
// handshake and shifts it out one bit per clock with per-bit valid and last.
module para_to_ser
    import para_ser_pkg::*;
#(
    parameter int WIDTH     = BYTE_W,
    parameter int MSB_FIRST = LSB_FIRST
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [WIDTH-1:0] data_in,
    input  logic             load,
    output logic             ready,
    output logic             out,
    output logic             out_valid,
    output logic             last
);

    localparam int            CW       = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

    p2s_state_e       state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic             out_q, out_d;
    logic             valid_q, valid_d;
    logic             last_q, last_d;
    logic             accept;

    // ready opens on the final bit so the next word follows with no gap
    assign ready     = en & ((state_q == S_IDLE) | ((state_q == S_SHIFT) & (cnt_q == LAST_CNT)));
    assign accept    = load & ready;
    assign out       = out_q;
    assign out_valid = valid_q & en;
    assign last      = last_q & en;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        shreg_d = shreg_q;
        out_d   = out_q;
        valid_d = valid_q;
        last_d  = last_q;
        if (accept) begin
            shreg_d = data_in;
            out_d   = (MSB_FIRST != 0) ? data_in[WIDTH-1] : data_in[0];
            cnt_d   = '0;
            valid_d = 1'b1;
            last_d  = 1'b0;
            state_d = S_SHIFT;
        end else if (en && state_q == S_SHIFT) begin
            if (cnt_q == LAST_CNT) begin
                state_d = S_IDLE;
                valid_d = 1'b0;
                out_d   = 1'b0;
                last_d  = 1'b0;
            end else begin
                cnt_d  = cnt_q + 1'b1;
                last_d = ((cnt_q + 1'b1) == LAST_CNT);
                // the shift register is consumed from the send end, so the
                // next bit is always adjacent to the one currently on out
                if (MSB_FIRST != 0) begin
                    out_d   = shreg_q[WIDTH-2];
                    shreg_d = shreg_q << 1;
                end else begin
                    out_d   = shreg_q[1];
                    shreg_d = shreg_q >> 1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            shreg_q <= '0;
            out_q   <= 1'b0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            shreg_q <= shreg_d;
            out_q   <= out_d;
            valid_q <= valid_d;
            last_q  <= last_d;
        end
    end

endmodule
